uart_tx_ctrl: RTL

Parametrised UART transmitter with a built-in transmit FIFO, configurable character width, runtime parity and one or two stop bits. It sits between the CPU-side UART register interface and the TX pin and is paced by an external bit-rate enable pulse, `clken_i`, from the existing baud generator. Software can queue up to `FIFO_DEPTH` characters without polling busy between writes.

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_tx_fifo.sv | 61 ++++++
 rtl/uart_tx_ctrl.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
package uart_pkg;

   // Frame sequencer states; 6 of the 8 encodings are used.
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4,
      STOP2  = 3'd5
   } tx_state_t;

   // Parity selector values; 2'b11 also means no parity.
   localparam logic [1:0] PAR_NONE = 2'b00;
   localparam logic [1:0] PAR_EVEN = 2'b01;
   localparam logic [1:0] PAR_ODD  = 2'b10;

   // True when the mode inserts a parity bit into the frame.
   function automatic logic parity_en(input logic [1:0] mode);
      return (mode == PAR_EVEN) || (mode == PAR_ODD);
   endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Transmit FIFO: circular buffer with registered head read on pop.
module uart_tx_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [WIDTH-1:0]         din,
   input  logic                     pop,
   output logic [WIDTH-1:0]         q,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     full,
   output logic                     empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic             wr_ok;
   logic             rd_ok;

   // A write into a full buffer is dropped even if a pop frees a slot this cycle.
   assign full  = (count == (AW+1)'(DEPTH));
   assign empty = (count == '0);
   assign level = count;
   assign wr_ok = push & ~full;
   assign rd_ok = pop & ~empty;

   // Storage array; contents need no reset since count gates every read.
   always_ff @(posedge clk) begin
      if (wr_ok) mem[wr_ptr] <= din;
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
         if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
         case ({wr_ok, rd_ok})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Head is captured on pop so the consumer sees it the following cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)        q <= '0;
      else if (rd_ok) q <= mem[rd_ptr];
   end

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmitter: FIFO-fed frame sequencer paced by an external bit tick.
module uart_tx_ctrl
   import uart_pkg::*;
#(
   parameter int DATA_BITS  = 8,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                          clk_50m_i,
   input  logic                          rst_i,
   input  logic [DATA_BITS-1:0]          din_i,
   input  logic                          wren_i,
   input  logic                          clken_i,
   input  logic [1:0]                    parity_mode_i,
   input  logic                          stop2_i,
   output logic                          tx_o,
   output logic                          tx_busy_o,
   output logic                          full_o,
   output logic [$clog2(FIFO_DEPTH):0]   level_o,
   output logic                          ovf_o
);

   localparam int CW = $clog2(DATA_BITS);
   localparam logic [CW-1:0] LAST_BIT = CW'(DATA_BITS - 1);

   tx_state_t            state;
   tx_state_t            state_nxt;
   logic [DATA_BITS-1:0] head;
   logic [DATA_BITS-1:0] shreg;
   logic [CW-1:0]        bit_cnt;
   logic                 par_acc;
   logic [1:0]           frame_par;
   logic                 frame_stop2;
   logic                 tx_q;
   logic                 tx_nxt;
   logic                 ovf_q;
   logic                 pop;
   logic                 load;
   logic                 shift_en;
   logic                 empty;

   uart_tx_fifo #(
      .WIDTH (DATA_BITS),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk_50m_i),
      .rst   (rst_i),
      .push  (wren_i),
      .din   (din_i),
      .pop   (pop),
      .q     (head),
      .level (level_o),
      .full  (full_o),
      .empty (empty)
   );

   assign tx_o      = tx_q;
   assign ovf_o     = ovf_q;
   assign tx_busy_o = (state != IDLE) || (level_o != '0);

   // Frame state register.
   always_ff @(posedge clk_50m_i or posedge rst_i) begin
      if (rst_i) state <= IDLE;
      else       state <= state_nxt;
   end

   // Next state, line value and datapath strobes; the line only moves on a tick.
   always_comb begin
      state_nxt = state;
      tx_nxt    = tx_q;
      pop       = 1'b0;
      load      = 1'b0;
      shift_en  = 1'b0;
      case (state)
         IDLE: begin
            tx_nxt = 1'b1;
            // A tick landing in the pop cycle is deliberately not used.
            if (!empty) begin
               pop       = 1'b1;
               state_nxt = START;
            end
         end
         START: begin
            if (clken_i) begin
               tx_nxt    = 1'b0;
               load      = 1'b1;
               state_nxt = DATA;
            end
         end
         DATA: begin
            if (clken_i) begin
               tx_nxt   = shreg[0];
               shift_en = 1'b1;
               if (bit_cnt == LAST_BIT)
                  state_nxt = parity_en(frame_par) ? PARITY : STOP;
            end
         end
         PARITY: begin
            if (clken_i) begin
               tx_nxt    = par_acc ^ (frame_par == PAR_ODD);
               state_nxt = STOP;
            end
         end
         STOP: begin
            if (clken_i) begin
               tx_nxt    = 1'b1;
               state_nxt = frame_stop2 ? STOP2 : IDLE;
            end
         end
         STOP2: begin
            if (clken_i) begin
               tx_nxt    = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: begin
            tx_nxt    = 1'b1;
            state_nxt = IDLE;
         end
      endcase
   end

   // Line register, per-frame config latch, shifter, parity and overflow flag.
   always_ff @(posedge clk_50m_i or posedge rst_i) begin
      if (rst_i) begin
         tx_q        <= 1'b1;
         ovf_q       <= 1'b0;
         frame_par   <= PAR_NONE;
         frame_stop2 <= 1'b0;
         shreg       <= '0;
         bit_cnt     <= '0;
         par_acc     <= 1'b0;
      end else begin
         tx_q  <= tx_nxt;
         ovf_q <= wren_i & full_o;
         // Config is sampled once per frame so mid-frame changes wait for the next pop.
         if (pop) begin
            frame_par   <= parity_mode_i;
            frame_stop2 <= stop2_i;
         end
         if (load) begin
            shreg   <= head;
            bit_cnt <= '0;
            par_acc <= 1'b0;
         end else if (shift_en) begin
            shreg   <= shreg >> 1;
            bit_cnt <= bit_cnt + 1'b1;
            par_acc <= par_acc ^ shreg[0];
         end
      end
   end

endmodule
